// File: rtl/fb_pkg.sv
// Shared types and default widths for the framebuffer write queue.
package fb_pkg;

    localparam int FB_ADDR_WIDTH   = 32;
    localparam int FB_COLOR_WIDTH  = 32;
    localparam int FB_DEPTH        = 16;
    localparam int FB_STALL_MARGIN = 4;
    localparam int FB_PERF_WIDTH   = 32;

    // One queued pixel write.
    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0]  addr;
        logic [FB_COLOR_WIDTH-1:0] data;
    } fb_wr_entry_t;

    // End-of-frame tracking states.
    typedef enum logic [1:0] {
        FB_WQ_RUN   = 2'd0,
        FB_WQ_DRAIN = 2'd1,
        FB_WQ_DONE  = 2'd2
    } fb_wq_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FB_PERF_WIDTH-1:0] fb_sat_inc(input logic [FB_PERF_WIDTH-1:0] value);
        if (value == {FB_PERF_WIDTH{1'b1}}) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fb_write_queue_if.sv
// Pixel write side and interconnect master side of the framebuffer write queue.
interface fb_write_queue_if
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int COLOR_WIDTH = FB_COLOR_WIDTH
);
    logic                   i_wr_req;
    logic [ADDR_WIDTH-1:0]  i_wr_addr;
    logic [COLOR_WIDTH-1:0] i_wr_data;
    logic                   o_stall;
    logic                   o_mem_req;
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic [COLOR_WIDTH-1:0] o_mem_wdata;
    logic                   i_mem_gnt;

    // Environment side: framebuffer stage plus interconnect.
    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_mem_gnt,
        input  o_stall, o_mem_req, o_mem_addr, o_mem_wdata
    );

    // Queue side.
    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_mem_gnt,
        output o_stall, o_mem_req, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/fb_wq_fifo.sv
// Circular storage for the write queue: pointers, occupancy and head mux.
// The head is forced to zero while the queue is empty so the bus never
// shows stale or uninitialised storage.
module fb_wq_fifo
    import fb_pkg::*;
#(
    parameter int  ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int  COLOR_WIDTH = FB_COLOR_WIDTH,
    parameter int  DEPTH       = FB_DEPTH,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int LVL_W       = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_req,
    input  logic [ADDR_WIDTH-1:0]  push_addr,
    input  logic [COLOR_WIDTH-1:0] push_data,
    input  logic                   pop_req,
    output logic                   push_ok,
    output logic                   pop_ok,
    output logic                   full,
    output logic [ADDR_WIDTH-1:0]  head_addr,
    output logic [COLOR_WIDTH-1:0] head_data,
    output logic [LVL_W-1:0]       level,
    output logic [LVL_W-1:0]       level_nxt
);
    localparam int               ENTRY_W  = ADDR_WIDTH + COLOR_WIDTH;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [LVL_W-1:0]   level_nxt_s;
    logic [ENTRY_W-1:0] head_s;

    // A push into a full queue is refused even if the head pops this cycle.
    assign full    = (level_r == FULL_LVL);
    assign push_ok = push_req & ~full;
    assign pop_ok  = pop_req & (level_r != LVL_ZERO);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_ok, pop_ok})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= LVL_ZERO;
        end else begin
            if (push_ok) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
        end
    end

    // Entry storage written on accepted pushes.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_r[wr_ptr_r] <= {push_addr, push_data};
        end
    end

    // Head entry mux, zero while empty.
    always_comb begin
        head_s = {ENTRY_W{1'b0}};
        if (level_r != LVL_ZERO) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {ENTRY_W{1'b0}};
        end
    end

    assign head_addr = head_s[ENTRY_W-1 -: ADDR_WIDTH];
    assign head_data = head_s[COLOR_WIDTH-1:0];
    assign level     = level_r;
    assign level_nxt = level_nxt_s;

endmodule

// File: rtl/fb_write_queue.sv
// Framebuffer write queue: buffers fire-and-forget pixel writes and issues
// them over a req/gnt port, with stall, sticky overflow and end-of-frame
// drain signalling.
// Optional macro FB_WQ_PERF_EN adds saturating push/drop/grant-wait counters.
module fb_write_queue
    import fb_pkg::*;
#(
    parameter int  ADDR_WIDTH   = FB_ADDR_WIDTH,
    parameter int  COLOR_WIDTH  = FB_COLOR_WIDTH,
    parameter int  DEPTH        = FB_DEPTH,
    parameter int  STALL_MARGIN = FB_STALL_MARGIN,
    localparam int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fb_write_queue_if.slave   bus,
    input  logic              i_frame_end,
    output logic              o_frame_done,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_overflow,
    input  logic              i_clr_overflow
`ifdef FB_WQ_PERF_EN
    ,
    output logic [31:0]       o_push_cnt,
    output logic [31:0]       o_drop_cnt,
    output logic [31:0]       o_gnt_wait_cnt
`endif
);
    localparam logic [LVL_W-1:0] STALL_LVL = LVL_W'(DEPTH - STALL_MARGIN);
    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};

    logic              push_ok_s;
    logic              pop_ok_s;
    logic              full_s;
    logic              drop_s;
    logic [LVL_W-1:0]  level_s;
    logic [LVL_W-1:0]  level_nxt_s;
    logic              stall_r;
    logic              overflow_r;
    logic              frame_done_r;
    fb_wq_state_e      state_r;
    fb_wq_state_e      state_nxt_s;
    logic [LVL_W-1:0]  drain_cnt_r;
    logic [LVL_W-1:0]  drain_cnt_nxt_s;
    logic [LVL_W-1:0]  remaining_s;

    fb_wq_fifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .COLOR_WIDTH (COLOR_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (bus.i_wr_req),
        .push_addr (bus.i_wr_addr),
        .push_data (bus.i_wr_data),
        .pop_req   (bus.i_mem_gnt),
        .push_ok   (push_ok_s),
        .pop_ok    (pop_ok_s),
        .full      (full_s),
        .head_addr (bus.o_mem_addr),
        .head_data (bus.o_mem_wdata),
        .level     (level_s),
        .level_nxt (level_nxt_s)
    );

    assign drop_s        = bus.i_wr_req & full_s;
    assign bus.o_mem_req = (level_s != LVL_ZERO);
    assign bus.o_stall   = stall_r;
    assign o_level       = level_s;
    assign o_overflow    = overflow_r;
    assign o_frame_done  = frame_done_r;

    // Stall follows the occupancy the queue will have next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_r <= 1'b0;
        end else begin
            stall_r <= (level_nxt_s >= STALL_LVL);
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (i_clr_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Frame tracking: count down the entries queued up to the frame end;
    // writes pushed afterwards belong to the next frame and are not waited on.
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        if (drain_cnt_r == LVL_ZERO) begin
            remaining_s = LVL_ZERO;
        end else begin
            remaining_s = drain_cnt_r - {{(LVL_W-1){1'b0}}, pop_ok_s};
        end
        case (state_r)
            FB_WQ_RUN: begin
                if (i_frame_end) begin
                    drain_cnt_nxt_s = level_nxt_s;
                    state_nxt_s     = FB_WQ_DRAIN;
                end else begin
                    state_nxt_s = FB_WQ_RUN;
                end
            end
            FB_WQ_DRAIN: begin
                drain_cnt_nxt_s = remaining_s;
                if (remaining_s == LVL_ZERO) begin
                    state_nxt_s = FB_WQ_DONE;
                end else begin
                    state_nxt_s = FB_WQ_DRAIN;
                end
            end
            FB_WQ_DONE: begin
                state_nxt_s = FB_WQ_RUN;
            end
            default: begin
                state_nxt_s     = FB_WQ_RUN;
                drain_cnt_nxt_s = LVL_ZERO;
            end
        endcase
    end

    // Frame tracking state, drain counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= FB_WQ_RUN;
            drain_cnt_r  <= LVL_ZERO;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            drain_cnt_r  <= drain_cnt_nxt_s;
            frame_done_r <= (state_nxt_s == FB_WQ_DONE);
        end
    end

`ifdef FB_WQ_PERF_EN
    logic [31:0] push_cnt_r;
    logic [31:0] drop_cnt_r;
    logic [31:0] gnt_wait_cnt_r;

    // Per-frame performance counters, restarted when the frame completes.
    always_ff @(posedge clk) begin
        if (!rst_n || frame_done_r) begin
            push_cnt_r     <= 32'd0;
            drop_cnt_r     <= 32'd0;
            gnt_wait_cnt_r <= 32'd0;
        end else begin
            if (push_ok_s) begin
                push_cnt_r <= fb_sat_inc(push_cnt_r);
            end
            if (drop_s) begin
                drop_cnt_r <= fb_sat_inc(drop_cnt_r);
            end
            if (bus.o_mem_req && !bus.i_mem_gnt) begin
                gnt_wait_cnt_r <= fb_sat_inc(gnt_wait_cnt_r);
            end
        end
    end

    assign o_push_cnt     = push_cnt_r;
    assign o_drop_cnt     = drop_cnt_r;
    assign o_gnt_wait_cnt = gnt_wait_cnt_r;
`endif

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed self-checking bench for fb_write_queue.
module tb_fb_write_queue;
    import fb_pkg::*;

    localparam int AW    = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_end;
    logic          frame_done;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clr_overflow;
`ifdef FB_WQ_PERF_EN
    logic [31:0]   push_cnt;
    logic [31:0]   drop_cnt;
    logic [31:0]   gnt_wait_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    fb_write_queue_if #(.ADDR_WIDTH(AW), .COLOR_WIDTH(CW)) bus();

    fb_write_queue #(
        .ADDR_WIDTH   (AW),
        .COLOR_WIDTH  (CW),
        .DEPTH        (DEPTH),
        .STALL_MARGIN (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .i_frame_end    (frame_end),
        .o_frame_done   (frame_done),
        .o_level        (level),
        .o_overflow     (overflow),
        .i_clr_overflow (clr_overflow)
`ifdef FB_WQ_PERF_EN
        ,
        .o_push_cnt     (push_cnt),
        .o_drop_cnt     (drop_cnt),
        .o_gnt_wait_cnt (gnt_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_drive(input logic [31:0] a, input logic [31:0] d);
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = a;
        bus.i_wr_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        frame_end     = 1'b0;
        clr_overflow  = 1'b0;
        bus.i_wr_req  = 1'b0;
        bus.i_wr_addr = 32'h0;
        bus.i_wr_data = 32'h0;
        bus.i_mem_gnt = 1'b0;
        tick();
        tick();
        check_val("rst_req", bus.o_mem_req, 1'b0);
        check_val("rst_level", level, 5'd0);
        check_val("rst_stall", bus.o_stall, 1'b0);
        check_val("rst_addr", bus.o_mem_addr, 32'h0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;

        // Single write with grant tied high: one request cycle at N+1.
        push_drive(32'h1000_0000, 32'hDEAD_BEEF);
        bus.i_mem_gnt = 1'b1;
        check_val("t1_req_n", bus.o_mem_req, 1'b0);
        tick();
        bus.i_wr_req = 1'b0;
        check_val("t1_req_n1", bus.o_mem_req, 1'b1);
        check_val("t1_addr", bus.o_mem_addr, 32'h1000_0000);
        check_val("t1_data", bus.o_mem_wdata, 32'hDEAD_BEEF);
        check_val("t1_level", level, 5'd1);
        tick();
        check_val("t1_req_n2", bus.o_mem_req, 1'b0);
        check_val("t1_level_end", level, 5'd0);
        tick();
        check_val("t1_gnt_ignored", level, 5'd0);
        bus.i_mem_gnt = 1'b0;

        // Fill to full with no grants, then a dropped 17th push.
        for (int i = 0; i < 16; i++) begin
            push_drive(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            tick();
            check_val("t2_level", level, 64'(i + 1));
            check_val("t2_stall", bus.o_stall, (i + 1 >= 12) ? 64'd1 : 64'd0);
        end
        push_drive(32'h0000_BAD0, 32'h0000_BAD0);
        clr_overflow = 1'b1;
        tick();
        bus.i_wr_req = 1'b0;
        clr_overflow = 1'b0;
        check_val("t2_full_level", level, 5'd16);
        check_val("t2_overflow_set", overflow, 1'b1);
`ifdef FB_WQ_PERF_EN
        check_val("t2_push_cnt", push_cnt, 32'd17);
        check_val("t2_drop_cnt", drop_cnt, 32'd1);
`endif
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_val("t2_overflow_clr", overflow, 1'b0);
        bus.i_mem_gnt = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_val("t2_drain_req", bus.o_mem_req, 1'b1);
            check_val("t2_drain_addr", bus.o_mem_addr, 32'h100 + 32'(4 * k));
            check_val("t2_drain_data", bus.o_mem_wdata, 32'hA000_0000 + 32'(k));
            tick();
        end
        check_val("t2_no_17th", bus.o_mem_req, 1'b0);
        check_val("t2_empty", level, 5'd0);
        bus.i_mem_gnt = 1'b0;
        tick();
        check_val("t2_stall_off", bus.o_stall, 1'b0);

        // Head held stable through grant wait, pops on first grant.
        push_drive(32'h40, 32'h5555_0040);
        tick();
        push_drive(32'h44, 32'h5555_0044);
        tick();
        bus.i_wr_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_val("t3_hold_addr", bus.o_mem_addr, 32'h40);
            check_val("t3_hold_data", bus.o_mem_wdata, 32'h5555_0040);
            tick();
        end
        bus.i_mem_gnt = 1'b1;
        check_val("t3_gnt_addr", bus.o_mem_addr, 32'h40);
        tick();
        check_val("t3_next_addr", bus.o_mem_addr, 32'h44);
        check_val("t3_next_level", level, 5'd1);
        tick();
        check_val("t3_empty", level, 5'd0);
        bus.i_mem_gnt = 1'b0;

        // Simultaneous push and pop at level 3, across pointer wrap.
        for (int j = 0; j < 3; j++) begin
            push_drive(32'h8000 + 32'(4 * j), 32'hC000_0000 + 32'(j));
            exp_q.push_back(j);
            tick();
        end
        bus.i_wr_req = 1'b0;
        check_val("t4_level3", level, 5'd3);
        for (int j = 3; j < 43; j++) begin
            push_drive(32'h8000 + 32'(4 * j), 32'hC000_0000 + 32'(j));
            bus.i_mem_gnt = 1'b1;
            check_val("t4_addr", bus.o_mem_addr, 32'h8000 + 32'(4 * exp_q[0]));
            check_val("t4_data", bus.o_mem_wdata, 32'hC000_0000 + 32'(exp_q[0]));
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(j);
            check_val("t4_level", level, 5'd3);
        end
        bus.i_wr_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check_val("t4_tail_addr", bus.o_mem_addr, 32'h8000 + 32'(4 * exp_q[0]));
            tick();
            void'(exp_q.pop_front());
        end
        bus.i_mem_gnt = 1'b0;
        check_val("t4_empty", level, 5'd0);

        // End of frame after 5 writes, 2 next-frame writes stay queued.
        for (int i = 0; i < 5; i++) begin
            push_drive(32'h2000 + 32'(4 * i), 32'hF000_0000 + 32'(i));
            tick();
        end
        bus.i_wr_req = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check_val("t5_done_early", frame_done, 1'b0);
        push_drive(32'h3000, 32'hE000_0000);
        tick();
        push_drive(32'h3004, 32'hE000_0001);
        tick();
        bus.i_wr_req = 1'b0;
        check_val("t5_level7", level, 5'd7);
        bus.i_mem_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_val("t5_done_wait", frame_done, 1'b0);
            check_val("t5_addr", bus.o_mem_addr, 32'h2000 + 32'(4 * k));
            tick();
        end
        bus.i_mem_gnt = 1'b0;
        check_val("t5_done_pulse", frame_done, 1'b1);
        check_val("t5_left", level, 5'd2);
        tick();
        check_val("t5_done_once", frame_done, 1'b0);
        check_val("t5_left_hold", level, 5'd2);
        check_val("t5_head_next", bus.o_mem_addr, 32'h3000);

        // Reset mid-stream at level 7 while draining a frame.
        for (int i = 0; i < 5; i++) begin
            push_drive(32'h4000 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            tick();
        end
        bus.i_wr_req = 1'b0;
        check_val("t6_level7", level, 5'd7);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        rst_n = 1'b0;
        tick();
        check_val("t6_rst_req", bus.o_mem_req, 1'b0);
        check_val("t6_rst_level", level, 5'd0);
        check_val("t6_rst_addr", bus.o_mem_addr, 32'h0);
        check_val("t6_rst_data", bus.o_mem_wdata, 32'h0);
        check_val("t6_rst_done", frame_done, 1'b0);
`ifdef FB_WQ_PERF_EN
        check_val("t6_rst_push_cnt", push_cnt, 32'd0);
        check_val("t6_rst_drop_cnt", drop_cnt, 32'd0);
        check_val("t6_rst_wait_cnt", gnt_wait_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check_val("t6_post_req", bus.o_mem_req, 1'b0);
        check_val("t6_post_level", level, 5'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check_val("t6_empty_done_n1", frame_done, 1'b0);
        tick();
        check_val("t6_empty_done_n2", frame_done, 1'b1);
        tick();
        check_val("t6_empty_done_n3", frame_done, 1'b0);
        push_drive(32'h5000, 32'h1234_5678);
        tick();
        bus.i_wr_req = 1'b0;
        check_val("t6_fresh_addr", bus.o_mem_addr, 32'h5000);
        check_val("t6_fresh_data", bus.o_mem_wdata, 32'h1234_5678);
        check_val("t6_fresh_level", level, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_write_queue.md
Name: fb_write_queue

Overview:
- Buffers pixel write requests emitted by the framebuffer address stage. That stage produces fire-and-forget one-cycle requests.
- Issues the buffered requests to the memory interconnect master port using a req/gnt handshake, so DRAM arbitration stalls never lose pixels.
- Sits directly downstream of the framebuffer stage and upstream of the interconnect.
- Provides a stall back to the fragment pipeline and end-of-frame drain signalling.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- COLOR_WIDTH, 32, pixel data width.
- DEPTH, 16, queue entries; must be a power of 2 and at least 4.
- STALL_MARGIN, 4, o_stall asserts when level >= DEPTH-STALL_MARGIN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_wr_req  in  1  one-cycle pixel write request from the framebuffer stage.
- i_wr_addr  in  ADDR_WIDTH  byte address of the pixel.
- i_wr_data  in  COLOR_WIDTH  pixel colour.
- o_stall  out  1  backpressure to the fragment pipeline.
- o_mem_req  out  1  request to the interconnect.
- o_mem_addr  out  ADDR_WIDTH  head entry address.
- o_mem_wdata  out  COLOR_WIDTH  head entry data.
- i_mem_gnt  in  1  interconnect accepts the head entry this cycle.
- i_frame_end  in  1  pulse: last pixel of the frame has been pushed (same cycle or earlier).
- o_frame_done  out  1  one-cycle pulse once all of the frame's writes have been granted.
- o_level  out  $clog2(DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky: a push was dropped.
- i_clr_overflow  in  1  clears o_overflow.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - Pointers and level go to 0; FSM goes to RUN.
  - All outputs go to 0: o_mem_req, o_mem_addr, o_mem_wdata, o_stall, o_frame_done, o_overflow, o_level.
  - Reset mid-transfer discards every queued entry. No request is issued in the cycle after reset.
- Storage is a circular array of DEPTH entries {addr, data}, with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Push: i_wr_req=1 and level<DEPTH at the start of the cycle → write the entry, wr_ptr++.
- Full:
  - A push while level==DEPTH is dropped and sets o_overflow, even if a grant occurs in the same cycle.
  - The dropped entry is never issued.
- Head presentation:
  - o_mem_req = (level!=0).
  - o_mem_addr/o_mem_wdata = array[rd_ptr], driven from flops through a mux.
  - An entry pushed in cycle N is presented in cycle N+1 at the earliest.
- Pop: o_mem_req & i_mem_gnt → rd_ptr++.
  - Addr/data are stable while req=1 and gnt=0.
  - i_mem_gnt while o_mem_req=0 is ignored.
- Level update: push-only +1, pop-only -1, simultaneous push and pop unchanged.
- o_stall: registered, equal to the level>=DEPTH-STALL_MARGIN condition evaluated on the next-state level.
- FIFO ordering is strict; no reordering or merging.
- FSM:
  - RUN: i_frame_end=1 → capture target = wr_ptr-after-this-cycle's-push and go to DRAIN.
  - DRAIN: rd_ptr==target (all frame entries granted) → DONE. Pushes for the next frame are accepted in DRAIN, but they are not waited on.
  - DONE: o_frame_done=1 for exactly one cycle → RUN.
  - i_frame_end while in DRAIN or DONE is ignored.
  - i_frame_end with an empty queue goes RUN→DRAIN→DONE, giving o_frame_done 2 cycles after the pulse.
- o_overflow: set on a dropped push; cleared by i_clr_overflow. Set has priority when both occur in the same cycle.

Optional Feature:
- Macro: FB_WQ_PERF_EN.
- Defined: adds 32-bit outputs o_push_cnt (accepted pushes), o_drop_cnt (dropped pushes) and o_gnt_wait_cnt (cycles with req=1 and gnt=0).
  - All three are saturating, reset to 0, and clear on the o_frame_done cycle.
- Undefined: those ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package fb_pkg holds:
  - typedef fb_wr_entry_t {addr, data} struct.
  - FSM enum fb_wq_state_e {RUN, DRAIN, DONE}.
  - Default width constants.
- One sub-module, fb_wq_fifo: storage, pointers, level and full/empty.
- The top level holds the FSM, stall, overflow and perf counters.

Test Plan:
- Single push addr=0x1000_0000 data=0xDEADBEEF with gnt tied 1 → o_mem_req high exactly one cycle, at N+1, with that addr/data; level returns to 0.
- Push 16 entries back-to-back with gnt=0 → o_stall high from the cycle after level reaches 12. 17th push dropped, o_overflow=1, level=16. Then gnt=1 → 16 grants in push order, 17th never appears.
- gnt=0 for 5 cycles with head at addr 0x40 → addr/data stable all 5 cycles; pop happens on the first gnt=1.
- Push and gnt simultaneously at level 3 → level stays 3; order preserved. Pointer wrap verified after 40 pushed/popped entries.
- Push 5, pulse i_frame_end, then push 2 more (next frame) → o_frame_done pulses one cycle after the 5th grant, with 2 entries still queued.
- rst_n=0 for one cycle with level=7 mid-stream → next cycle o_mem_req=0, level=0, FSM RUN. With FB_WQ_PERF_EN, counters read 0.
